// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared control struct, access sizes and load extension for the MEM stage
package memory_stage_pkg;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic [2:0] funct3;
   } control_type;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_e;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } mem_state_e;

   localparam int CNT_W = 16;

   // funct3[2] selects zero extension; the lane is brought down to bit 0 first
   function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                               input logic [31:0] rdata,
                                               input logic [1:0]  offset);
      logic [31:0] shifted;
      shifted = rdata >> {offset, 3'b000};
      case (funct3)
         3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  return {24'h0, shifted[7:0]};
         3'b101:  return {16'h0, shifted[15:0]};
         default: return shifted;
      endcase
   endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// rtl/memory_stage_mem_align.sv - combinational byte-lane enables, store replication, alignment and load extraction
module mem_align
   import memory_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic        aligned,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   mem_size_e size;
   assign size = mem_size_e'(funct3[1:0]);

   always_comb begin
      aligned = 1'b0;
      be      = 4'b0000;
      wdata   = store_data;
      case (size)
         MEM_BYTE: begin
            aligned = 1'b1;
            be      = 4'b0001 << addr[1:0];
            wdata   = {4{store_data[7:0]}};
         end
         MEM_HALF: begin
            aligned = ~addr[0];
            be      = 4'b0011 << addr[1:0];
            wdata   = {2{store_data[15:0]}};
         end
         MEM_WORD: begin
            aligned = (addr[1:0] == 2'b00);
            be      = 4'b1111;
            wdata   = store_data;
         end
         default: begin
            aligned = 1'b0;
            be      = 4'b0000;
            wdata   = store_data;
         end
      endcase
   end

   assign load_data = load_extend(funct3, rdata, addr[1:0]);

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage: data-memory handshake, wait-state stall, watchdog and MEM/WB register
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        valid_in,
   input  control_type control_in,
   input  logic [31:0] alu_data_in,
   input  logic [31:0] memory_data_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic        misaligned_error,
   output logic        bus_error,
   output logic        valid_out,
   output control_type control_out,
   output logic [31:0] alu_data_out,
   output logic [31:0] mem_data_out
);

   mem_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic        aligned;
   logic [31:0] load_data;
   logic        mem_op;
   logic        acc;
   logic        misaligned;
   logic        timeout_hit;
   logic        timeout_err;

   mem_align u_align (
      .funct3     (control_in.funct3),
      .addr       (alu_data_in),
      .store_data (memory_data_in),
      .rdata      (dmem_rdata),
      .aligned    (aligned),
      .be         (dmem_be),
      .wdata      (dmem_wdata),
      .load_data  (load_data)
   );

   assign mem_op     = control_in.mem_read | control_in.mem_write;
   // Gating with reset_n keeps the bus and hazard unit quiet while reset is held
   assign acc        = reset_n & valid_in & mem_op & aligned;
   assign misaligned = valid_in & mem_op & ~aligned;

   assign timeout_hit = (state == ST_WAIT) && (cnt == CNT_W'(TIMEOUT_CYCLES));
   // A real ack arriving on the timeout cycle still delivers its data
   assign timeout_err = timeout_hit & ~dmem_ack;

   assign dmem_req  = acc;
   assign dmem_we   = control_in.mem_write;
   assign dmem_addr = {alu_data_in[31:2], 2'b00};
   assign stall_out = acc & ~dmem_ack & ~timeout_hit;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (acc && !dmem_ack) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (!acc || dmem_ack || timeout_hit) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (cnt != CNT_W'(TIMEOUT_CYCLES)) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_out        <= 1'b0;
         control_out      <= '0;
         alu_data_out     <= '0;
         mem_data_out     <= '0;
         misaligned_error <= 1'b0;
         bus_error        <= 1'b0;
      end else if (stall_out) begin
         valid_out        <= 1'b0;
         control_out      <= '0;
         misaligned_error <= 1'b0;
         bus_error        <= 1'b0;
      end else begin
         valid_out             <= valid_in;
         control_out           <= control_in;
         control_out.reg_write <= control_in.reg_write & ~misaligned;
         alu_data_out          <= alu_data_in;
         mem_data_out          <= (acc && control_in.mem_read && !timeout_err) ? load_data : 32'h0;
         misaligned_error      <= misaligned;
         bus_error             <= acc & timeout_err;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_in;
   control_type control_in;
   logic [31:0] alu_data_in;
   logic [31:0] memory_data_in;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall_out;
   logic        misaligned_error;
   logic        bus_error;
   logic        valid_out;
   control_type control_out;
   logic [31:0] alu_data_out;
   logic [31:0] mem_data_out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        valid;
      logic        reg_write;
      logic [31:0] alu;
      logic [31:0] mem;
      logic        berr;
      logic        merr;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   memory_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .valid_in         (valid_in),
      .control_in       (control_in),
      .alu_data_in      (alu_data_in),
      .memory_data_in   (memory_data_in),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_be          (dmem_be),
      .dmem_wdata       (dmem_wdata),
      .dmem_ack         (dmem_ack),
      .dmem_rdata       (dmem_rdata),
      .stall_out        (stall_out),
      .misaligned_error (misaligned_error),
      .bus_error        (bus_error),
      .valid_out        (valid_out),
      .control_out      (control_out),
      .alu_data_out     (alu_data_out),
      .mem_data_out     (mem_data_out)
   );

   function automatic control_type mk(input logic rd, input logic wr, input logic [2:0] f3, input logic rw);
      control_type c;
      c = '0;
      c.mem_read   = rd;
      c.mem_write  = wr;
      c.funct3     = f3;
      c.reg_write  = rw;
      c.mem_to_reg = rd;
      return c;
   endfunction

   function automatic bit aligned_model(input logic [2:0] f3, input logic [31:0] a);
      case (f3[1:0])
         2'b00:   return 1'b1;
         2'b01:   return a[0] == 1'b0;
         2'b10:   return a[1:0] == 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   task automatic idle();
      valid_in       = 1'b0;
      control_in     = '0;
      dmem_ack       = 1'b0;
      alu_data_in    = '0;
      memory_data_in = '0;
   endtask

   // ack_at: request cycle index carrying dmem_ack, negative for never
   task automatic do_access(input control_type c, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rd, input int ack_at, input logic [3:0] ebe,
                            input logic [31:0] ewd, input logic [31:0] emem, input string name);
      exp_t e;
      exp_t got;
      int   nst;
      bit   mem_op, misal, done;
      mem_op = c.mem_read | c.mem_write;
      misal  = mem_op && !aligned_model(c.funct3, a);
      nst    = (!mem_op || misal) ? 0 : ((ack_at < 0) ? TMO : ack_at);
      e.valid     = 1'b1;
      e.reg_write = c.reg_write & !misal;
      e.alu       = a;
      e.mem       = emem;
      e.berr      = mem_op && !misal && (ack_at < 0);
      e.merr      = misal;
      exp_q.push_back(e);
      valid_in = 1'b1; control_in = c; alu_data_in = a; memory_data_in = d; dmem_rdata = rd;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         dmem_ack = (k == ack_at);
         @(negedge clk);
         checks++;
         if (stall_out !== (k < nst)) begin
            errors++; $display("FAIL %s stall k=%0d: got %b want %b", name, k, stall_out, k < nst);
         end
         checks++;
         if (dmem_req !== (mem_op && !misal)) begin
            errors++; $display("FAIL %s req k=%0d: got %b want %b", name, k, dmem_req, mem_op && !misal);
         end
         checks++;
         if (dmem_addr !== {a[31:2], 2'b00}) begin
            errors++; $display("FAIL %s addr k=%0d: got %h want %h", name, k, dmem_addr, {a[31:2], 2'b00});
         end
         if (k == 0 && mem_op && !misal) begin
            checks++;
            if (dmem_be !== ebe || dmem_we !== c.mem_write) begin
               errors++; $display("FAIL %s be/we: got %b/%b want %b/%b", name, dmem_be, dmem_we, ebe, c.mem_write);
            end
            if (c.mem_write) begin
               checks++;
               if (dmem_wdata !== ewd) begin
                  errors++; $display("FAIL %s wdata: got %h want %h", name, dmem_wdata, ewd);
               end
            end
         end
         @(posedge clk); #1;
         if (k < nst) begin
            checks++;
            if (valid_out !== 1'b0) begin
               errors++; $display("FAIL %s bubble k=%0d: got valid_out=%b want 0", name, k, valid_out);
            end
         end else begin
            got.valid = valid_out; got.reg_write = control_out.reg_write; got.alu = alu_data_out;
            got.mem = mem_data_out; got.berr = bus_error; got.merr = misaligned_error;
            e = exp_q.pop_front();
            checks++;
            if (got.valid !== e.valid || got.reg_write !== e.reg_write || got.alu !== e.alu ||
                got.mem !== e.mem || got.berr !== e.berr || got.merr !== e.merr) begin
               errors++;
               $display("FAIL %s result: got v=%b rw=%b alu=%h mem=%h be=%b me=%b want v=%b rw=%b alu=%h mem=%h be=%b me=%b",
                        name, got.valid, got.reg_write, got.alu, got.mem, got.berr, got.merr,
                        e.valid, e.reg_write, e.alu, e.mem, e.berr, e.merr);
            end
            done = 1'b1;
         end
      end
      if (!done) begin
         errors++; checks++;
         $display("FAIL %s completion: got none within budget want one", name);
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      valid_in = 1'b1; control_in = mk(1, 0, 3'b010, 1); alu_data_in = 32'h100;
      #12;
      checks++;
      if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
         errors++; $display("FAIL reset_req: got req=%b stall=%b want 0/0", dmem_req, stall_out);
      end
      checks++;
      if (valid_out !== 1'b0 || control_out !== '0 || alu_data_out !== 0 || mem_data_out !== 0 ||
          misaligned_error !== 1'b0 || bus_error !== 1'b0) begin
         errors++; $display("FAIL reset_regs: got v=%b ctl=%h alu=%h mem=%h want all 0",
                            valid_out, control_out, alu_data_out, mem_data_out);
      end
      idle();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_loads();
      do_access(mk(1, 0, 3'b010, 1), 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF, "lw");
      do_access(mk(1, 0, 3'b000, 1), 32'h103, 32'h0, 32'h80112233, 0, 4'b1000, 32'h0, 32'hFFFFFF80, "lb");
      do_access(mk(1, 0, 3'b100, 1), 32'h103, 32'h0, 32'h80112233, 0, 4'b1000, 32'h0, 32'h00000080, "lbu");
      do_access(mk(1, 0, 3'b001, 1), 32'h106, 32'h0, 32'h9ABC1234, 0, 4'b1100, 32'h0, 32'hFFFF9ABC, "lh");
      do_access(mk(1, 0, 3'b101, 1), 32'h106, 32'h0, 32'h9ABC1234, 0, 4'b1100, 32'h0, 32'h00009ABC, "lhu");
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      do_access(mk(0, 1, 3'b001, 0), 32'h202, 32'h0000ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD, 32'h0, "sh");
      do_access(mk(0, 1, 3'b000, 0), 32'h301, 32'h11223344, 32'h0, 0, 4'b0010, 32'h44444444, 32'h0, "sb");
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_wait();
      do_access(mk(1, 0, 3'b010, 1), 32'h400, 32'h0, 32'h01234567, 3, 4'b1111, 32'h0, 32'h01234567, "lw_wait");
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      do_access(mk(1, 0, 3'b010, 1), 32'h500, 32'h0, 32'hCAFEF00D, -1, 4'b1111, 32'h0, 32'h0, "lw_timeout");
      idle();
      @(posedge clk); #1;
      checks++;
      if (bus_error !== 1'b0) begin
         errors++; $display("FAIL bus_error_pulse: got %b want 0 one cycle later", bus_error);
      end
   endtask

   task automatic test_misaligned();
      do_access(mk(1, 0, 3'b010, 1), 32'h102, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, "lw_misaligned");
      do_access(mk(0, 1, 3'b001, 0), 32'h203, 32'h5555, 32'h0, 0, 4'b0000, 32'h0, 32'h0, "sh_misaligned");
      idle();
      @(posedge clk); #1;
      checks++;
      if (misaligned_error !== 1'b0) begin
         errors++; $display("FAIL misaligned_pulse: got %b want 0", misaligned_error);
      end
   endtask

   task automatic test_nonmem();
      do_access(mk(0, 0, 3'b000, 1), 32'h12345677, 32'hFFFF, 32'hFFFFFFFF, 0, 4'b0000, 32'h0, 32'h0, "alu_pass");
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f3s[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0]  f3;
      logic [31:0] a, rd, em;
      logic [3:0]  ebe;
      logic [1:0]  off;
      for (int i = 0; i < 8; i++) begin
         f3 = f3s[$urandom_range(0, 4)];
         a  = {$urandom_range(0, 65535), 2'b00} & 32'h0000FFFC;
         off = 2'($urandom_range(0, 3));
         if (f3[1:0] == 2'b01) off[0] = 1'b0;
         if (f3[1:0] == 2'b10) off = 2'b00;
         a[1:0] = off;
         rd = $urandom;
         case (f3)
            3'b000:  begin em = {{24{rd[8*off+7]}}, rd[8*off +: 8]};  ebe = 4'b0001 << off; end
            3'b100:  begin em = {24'h0, rd[8*off +: 8]};              ebe = 4'b0001 << off; end
            3'b001:  begin em = {{16{rd[8*off+15]}}, rd[8*off +: 16]}; ebe = (off == 2'b00) ? 4'b0011 : 4'b1100; end
            3'b101:  begin em = {16'h0, rd[8*off +: 16]};             ebe = (off == 2'b00) ? 4'b0011 : 4'b1100; end
            default: begin em = rd;                                   ebe = 4'b1111; end
         endcase
         do_access(mk(1, 0, f3, 1), a, 32'h0, rd, int'($urandom_range(0, 2)), ebe, 32'h0, em, "b2b");
      end
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset_wait();
      valid_in = 1'b1; control_in = mk(1, 0, 3'b010, 1); alu_data_in = 32'h600; dmem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (stall_out !== 1'b1 || dmem_req !== 1'b1) begin
         errors++; $display("FAIL rst_wait_pre: got stall=%b req=%b want 1/1", stall_out, dmem_req);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || stall_out !== 1'b0 || valid_out !== 1'b0) begin
         errors++; $display("FAIL rst_wait_drop: got req=%b stall=%b valid=%b want 0/0/0", dmem_req, stall_out, valid_out);
      end
      idle();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus_error !== 1'b0 || valid_out !== 1'b0) begin
         errors++; $display("FAIL rst_wait_quiet: got berr=%b valid=%b want 0/0", bus_error, valid_out);
      end
      do_access(mk(1, 0, 3'b010, 1), 32'h700, 32'h0, 32'h13572468, 0, 4'b1111, 32'h0, 32'h13572468, "lw_after_reset");
      idle();
      @(posedge clk); #1;
   endtask

   initial begin
      dmem_rdata = '0;
      test_reset();
      test_loads();
      test_store();
      test_wait();
      test_timeout();
      test_misaligned();
      test_nonmem();
      test_back_to_back();
      test_reset_wait();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
